// File: rtl/coh_snoop_agent_pkg.sv
// Shared coherence types for the snooping agent and its arbiter.
// MSI line states, requester FSM states, bus op kinds and fill-source codes.
package common;

   typedef enum logic [1:0] {
      INVALID  = 2'b00,
      SHARED   = 2'b01,
      MODIFIED = 2'b10
   } coh_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      XFER = 2'b10,
      FILL = 2'b11
   } agent_state_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'b00,
      OP_WR  = 2'b01,
      OP_UPG = 2'b10
   } req_op_t;

   localparam logic [1:0] SOURCE_DMEM       = 2'b00;
   localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;
   localparam int         ADDR_W            = 13;

endpackage

// File: rtl/coh_snoop_agent_tag_dir.sv
// Direct-mapped MSI snoop-tag directory: one combinational lookup,
// one snoop-update port and one fill port that wins on an index collision.
module snoop_tag_dir
   import common::*;
#(
   parameter int SETS   = 8,
   parameter int LINE_W = ADDR_W - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LINE_W-1:0] lk_line,
   output coh_state_t        lk_state,
   input  logic              sn_we,
   input  logic [LINE_W-1:0] sn_line,
   input  coh_state_t        sn_state,
   input  logic              fill_we,
   input  logic [LINE_W-1:0] fill_line,
   input  coh_state_t        fill_state
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = LINE_W - IDX_W;

   logic [SETS-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [SETS-1:0][1:0]       st_q, st_d;

   logic [IDX_W-1:0] lk_idx, sn_idx, fill_idx;

   assign lk_idx   = lk_line[IDX_W-1:0];
   assign sn_idx   = sn_line[IDX_W-1:0];
   assign fill_idx = fill_line[IDX_W-1:0];

   // A tag mismatch reads as INVALID regardless of the stored state.
   assign lk_state = (tag_q[lk_idx] == lk_line[LINE_W-1:IDX_W])
                     ? coh_state_t'(st_q[lk_idx]) : INVALID;

   always_comb begin
      tag_d = tag_q;
      st_d  = st_q;
      if (sn_we) begin
         st_d[sn_idx] = sn_state;
      end
      if (fill_we) begin
         tag_d[fill_idx] = fill_line[LINE_W-1:IDX_W];
         st_d[fill_idx]  = fill_state;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0;
         st_q  <= '0;
      end else begin
         tag_q <= tag_d;
         st_q  <= st_d;
      end
   end

endmodule

// File: rtl/coh_snoop_agent.sv
// Per-CPU coherence agent: turns D-cache misses/upgrades into held bus
// requests and answers the arbiter's snoops against the tag directory.
module coh_snoop_agent
   import common::*;
#(
   parameter int SETS     = 8,
   parameter int XFER_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd_miss,
   input  logic              cpu_wr_miss,
   input  logic              cpu_wr_shared,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_done,
   output logic              cpu_stall,
   output logic              read_miss,
   output logic              write_miss,
   output logic              invalidate,
   output logic [ADDR_W-1:0] BICO,
   input  logic              grant,
   input  logic [1:0]        datasel,
   input  logic              search,
   input  logic [ADDR_W-1:0] BOCI,
   output logic              search_found,
   output logic [1:0]        block_state,
   input  logic              inv_from_other,
   output logic [1:0]        fwd_src,
   output agent_state_t      dbg_state
);

   localparam int              CNT_W    = (XFER_CYC > 1) ? $clog2(XFER_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XFER_CYC - 1);

   agent_state_t      state_q, state_d;
   req_op_t           op_q, op_d;
   logic [ADDR_W-1:0] bico_q, bico_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        fwd_src_q, fwd_src_d;
   logic              search_found_q, search_found_d;

   coh_state_t blk_state, sn_state, fill_state;
   logic       snoop_hit, sn_we, fill_we, upgrade_lost;
   logic       unused_offset;

   assign unused_offset = ^BOCI[1:0];

   snoop_tag_dir #(.SETS(SETS)) u_dir (
      .clk        (clk),
      .rst        (rst),
      .lk_line    (BOCI[ADDR_W-1:2]),
      .lk_state   (blk_state),
      .sn_we      (sn_we),
      .sn_line    (BOCI[ADDR_W-1:2]),
      .sn_state   (sn_state),
      .fill_we    (fill_we),
      .fill_line  (bico_q[ADDR_W-1:2]),
      .fill_state (fill_state)
   );

   assign snoop_hit = (blk_state != INVALID);

   // Snoop side runs every cycle; an invalidate overrides a concurrent search.
   always_comb begin
      sn_we    = 1'b0;
      sn_state = INVALID;
      if (inv_from_other && snoop_hit) begin
         sn_we    = 1'b1;
         sn_state = INVALID;
      end else if (search && (blk_state == MODIFIED)) begin
         sn_we    = 1'b1;
         sn_state = SHARED;
      end
   end

   assign search_found_d = search && !inv_from_other && snoop_hit;

   // A pending upgrade whose Shared copy is snooped away must refetch the data.
   assign upgrade_lost = (state_q == REQ) && (op_q == OP_UPG) && inv_from_other
                         && snoop_hit && (BOCI[ADDR_W-1:2] == bico_q[ADDR_W-1:2]);

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      bico_d     = bico_q;
      cnt_d      = cnt_q;
      fwd_src_d  = fwd_src_q;
      fill_we    = 1'b0;
      fill_state = INVALID;
      case (state_q)
         IDLE: begin
            if (cpu_wr_miss || cpu_rd_miss || cpu_wr_shared) begin
               state_d = REQ;
               bico_d  = cpu_addr;
               if (cpu_wr_miss)      op_d = OP_WR;
               else if (cpu_rd_miss) op_d = OP_RD;
               else                  op_d = OP_UPG;
            end
         end
         REQ: begin
            if (upgrade_lost) op_d = OP_WR;
            if (grant) begin
               cnt_d   = '0;
               state_d = ((op_q == OP_UPG) && !upgrade_lost) ? FILL : XFER;
            end
         end
         XFER: begin
            if (cnt_q == '0) fwd_src_d = datasel;
            if (cnt_q == CNT_LAST) state_d = FILL;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         FILL: begin
            fill_we    = 1'b1;
            fill_state = (op_q == OP_RD) ? SHARED : MODIFIED;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         op_q           <= OP_RD;
         bico_q         <= '0;
         cnt_q          <= '0;
         fwd_src_q      <= SOURCE_DMEM;
         search_found_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         bico_q         <= bico_d;
         cnt_q          <= cnt_d;
         fwd_src_q      <= fwd_src_d;
         search_found_q <= search_found_d;
      end
   end

   // Bus request lines are levels held in REQ; grant is the only acknowledge.
   assign read_miss    = (state_q == REQ) && (op_q == OP_RD);
   assign write_miss   = (state_q == REQ) && (op_q == OP_WR);
   assign invalidate   = (state_q == REQ) && (op_q == OP_UPG);
   assign cpu_stall    = (state_q != IDLE);
   assign cpu_done     = (state_q == FILL);
   assign BICO         = bico_q;
   assign fwd_src      = fwd_src_q;
   assign search_found = search_found_q;
   assign block_state  = blk_state;
   assign dbg_state    = state_q;

endmodule
